fifo_fill_arbiter: RTL and testbench
====================================

FIFO_FILL_ARBITER -- requirements
Module: fifo_fill_arbiter

Interface
REQ-001 Parameter AW, 16, memory word-address width.
REQ-002 Parameter BURST, 9, words fetched per grant (>=2).
REQ-003 Parameter CW, 8, burst counter width (2^CW > BURST).
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-low.
REQ-006 cfg_load  in  1  one-cycle pulse; loads pix_base/wt_base into the address pointers.
REQ-007 pix_base, wt_base  in  AW  start addresses of the pixel and weight regions.
REQ-008 pix_req, wt_req  in  1  one-cycle request pulses from the pixel/weight FIFO fill logic.
REQ-009 pix_afull, wt_afull  in  1  FIFO almost-full; asserted with at least 1 free slot remaining.
REQ-010 mem_rd_en  out  1  shared memory read strobe; read data valid 1 cycle later.
REQ-011 mem_addr  out  AW  read address, valid while mem_rd_en=1.
REQ-012 pix_fifo_wr_en, wt_fifo_wr_en  out  1  FIFO write enables.
REQ-013 grant_pix  out  1  1 while a pixel burst is active, 0 otherwise.
REQ-014 busy  out  1  1 in any state other than IDLE.
REQ-015 burst_done  out  1  one-cycle pulse on the cycle after the last FIFO write of a burst.

Function
REQ-016 Pending flags pix_pend and wt_pend are set by the respective req pulse and cleared when that source is granted; if a req pulse and a grant fall in the same cycle, the flag stays set.
REQ-017 FSM states: IDLE, PIX, WT, DRAIN.
REQ-018 IDLE: if exactly one flag is pending, go to its state; if both are pending, grant the source not served last (round-robin); the first grant after reset goes to PIX.
REQ-019 PIX/WT: mem_rd_en=1 on every cycle in which the granted source's afull=0; mem_addr=granted pointer; the pointer and the burst counter increment per issued read.
REQ-020 While the granted afull=1, mem_rd_en=0 and the pointer and counter hold; no timeout applies.
REQ-021 When the read at count BURST-1 is issued, the FSM moves to DRAIN next cycle and the counter clears.
REQ-022 DRAIN lasts exactly 1 cycle, then IDLE; burst_done pulses in the cycle after DRAIN.
REQ-023 FIFO write enable = mem_rd_en registered by 1 cycle, routed to the FIFO of the source that issued the read; the two write enables are never 1 simultaneously.
REQ-024 grant_pix is 1 in PIX and in the DRAIN following PIX.
REQ-025 Pointers are AW bits and wrap 2^AW-1 -> 0 silently.
REQ-026 cfg_load has priority over an increment in the same cycle; cfg_load during a burst takes effect on the next read.
REQ-027 Req pulses arriving during a burst are recorded in the pending flags and never interrupt the active burst.
REQ-028 Exactly BURST reads and exactly BURST writes occur per grant.

Reset
REQ-029 On reset=0, immediately: state=IDLE; pending flags=0; counter=0; pointers=0; round-robin last=WT; all outputs=0.
REQ-030 Reset mid-burst aborts the burst with no further reads or writes; any write in flight is dropped.
REQ-031 The first request after reset deassertion is serviced normally.

Verification
REQ-032 cfg_load pix_base=0x0100, then pix_req -> PIX reads at 0x0100..0x0108 on 9 consecutive cycles; pix_fifo_wr_en high for 9 cycles, lagging by 1; burst_done 1 cycle after the last write.
REQ-033 pix_req and wt_req in the same cycle after reset -> pixel burst first, weight burst starts 2 cycles after the last pixel read (DRAIN+IDLE); the next simultaneous pair goes to WT first.
REQ-034 pix_afull=1 for 3 cycles after the 4th read -> 3-cycle gap in mem_rd_en; addresses continue at base+4; total still 9 writes.
REQ-035 wt_base=0xFFFC, wt_req -> addresses 0xFFFC..0xFFFF then 0x0000..0x0004.
REQ-036 reset=0 after the 5th read of a burst -> all outputs 0 in the same cycle; after release, no activity until a new req arrives.
REQ-037 wt_req pulse during an active pixel burst -> weight burst follows the pixel burst; no pixel write or read is lost.

Source files
------------

// File: rtl/fifo_fill_arbiter.sv
// Shared-memory read arbiter: fills pixel and weight FIFOs in fixed-length bursts,
// granting the two sources round-robin when both are waiting.
module fifo_fill_arbiter #(
    parameter int unsigned AW    = 16,
    parameter int unsigned BURST = 9,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_load,
    input  logic [AW-1:0] pix_base,
    input  logic [AW-1:0] wt_base,
    input  logic          pix_req,
    input  logic          wt_req,
    input  logic          pix_afull,
    input  logic          wt_afull,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    output logic          pix_fifo_wr_en,
    output logic          wt_fifo_wr_en,
    output logic          grant_pix,
    output logic          busy,
    output logic          burst_done
);

    typedef enum logic [1:0] {IDLE, PIX, WT, DRAIN} state_t;

    localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);

    state_t        state_q, state_d;
    logic          pix_pend_q, pix_pend_d;
    logic          wt_pend_q, wt_pend_d;
    logic          last_wt_q, last_wt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] pix_ptr_q, pix_ptr_d;
    logic [AW-1:0] wt_ptr_q, wt_ptr_d;
    logic          pix_wr_q, pix_wr_d;
    logic          wt_wr_q, wt_wr_d;
    logic          done_q, done_d;

    logic          grant_pix_now, grant_wt_now;
    logic          rd_pix, rd_wt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_pend_q <= 1'b0;
            wt_pend_q  <= 1'b0;
            last_wt_q  <= 1'b1;
            cnt_q      <= '0;
            pix_ptr_q  <= '0;
            wt_ptr_q   <= '0;
            pix_wr_q   <= 1'b0;
            wt_wr_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            pix_pend_q <= pix_pend_d;
            wt_pend_q  <= wt_pend_d;
            last_wt_q  <= last_wt_d;
            cnt_q      <= cnt_d;
            pix_ptr_q  <= pix_ptr_d;
            wt_ptr_q   <= wt_ptr_d;
            pix_wr_q   <= pix_wr_d;
            wt_wr_q    <= wt_wr_d;
            done_q     <= done_d;
        end
    end

    // Pixel wins a tie only when weight was the most recent grant.
    always_comb begin
        state_d       = state_q;
        grant_pix_now = 1'b0;
        grant_wt_now  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_pend_q && (!wt_pend_q || last_wt_q)) begin
                    state_d       = PIX;
                    grant_pix_now = 1'b1;
                end else if (wt_pend_q) begin
                    state_d      = WT;
                    grant_wt_now = 1'b1;
                end
            end
            PIX:     if (rd_pix && (cnt_q == LAST_CNT)) state_d = DRAIN;
            WT:      if (rd_wt && (cnt_q == LAST_CNT)) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_pix         = (state_q == PIX) && !pix_afull;
        rd_wt          = (state_q == WT) && !wt_afull;
        mem_rd_en      = rd_pix || rd_wt;
        mem_addr       = rd_pix ? pix_ptr_q : (rd_wt ? wt_ptr_q : '0);
        grant_pix      = (state_q == PIX) || ((state_q == DRAIN) && !last_wt_q);
        busy           = (state_q != IDLE);
        pix_fifo_wr_en = pix_wr_q;
        wt_fifo_wr_en  = wt_wr_q;
        burst_done     = done_q;
    end

    // A request in the grant cycle re-arms the flag; cfg_load beats the increment.
    always_comb begin
        pix_pend_d = (pix_pend_q && !grant_pix_now) || pix_req;
        wt_pend_d  = (wt_pend_q && !grant_wt_now) || wt_req;
        last_wt_d  = grant_wt_now ? 1'b1 : (grant_pix_now ? 1'b0 : last_wt_q);
        cnt_d      = cnt_q;
        if (rd_pix || rd_wt) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
        end
        pix_ptr_d = cfg_load ? pix_base : (rd_pix ? pix_ptr_q + 1'b1 : pix_ptr_q);
        wt_ptr_d  = cfg_load ? wt_base : (rd_wt ? wt_ptr_q + 1'b1 : wt_ptr_q);
        pix_wr_d  = rd_pix;
        wt_wr_d   = rd_wt;
        done_d    = (state_q == DRAIN);
    end

endmodule

// File: tb/tb_fifo_fill_arbiter.sv
// Scoreboard bench for fifo_fill_arbiter: a per-cycle service model predicts every
// read, write and burst_done; a separate monitor compares what the DUT presents.
module tb_fifo_fill_arbiter;

    localparam int BURST = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_load = 1'b0;
    logic [15:0] pix_base = '0;
    logic [15:0] wt_base = '0;
    logic        pix_req = 1'b0;
    logic        wt_req = 1'b0;
    logic        pix_afull = 1'b0;
    logic        wt_afull = 1'b0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic        pix_fifo_wr_en;
    logic        wt_fifo_wr_en;
    logic        grant_pix;
    logic        busy;
    logic        burst_done;

    fifo_fill_arbiter #(.AW(16), .BURST(BURST), .CW(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load),
        .pix_base(pix_base), .wt_base(wt_base),
        .pix_req(pix_req), .wt_req(wt_req),
        .pix_afull(pix_afull), .wt_afull(wt_afull),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .pix_fifo_wr_en(pix_fifo_wr_en), .wt_fifo_wr_en(wt_fifo_wr_en),
        .grant_pix(grant_pix), .busy(busy), .burst_done(burst_done)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int src; logic [15:0] addr; } rd_t;
    typedef struct { int cyc; int src; } wr_t;

    rd_t rdq[$];
    wr_t wrq[$];
    int  dq[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_rd = 0;

    always @(posedge clk) cyc++;

    // Reference: source 0 = pixel, 1 = weight. A burst owns the memory for BURST
    // issued reads, then one drain cycle, then one arbitration slot.
    int          m_rem = 0;
    int          m_src = 0;
    int          m_last = 1;
    bit          m_drain = 0;
    bit          m_pend[2];
    logic [15:0] m_ptr[2];

    always @(negedge clk) begin
        bit af[2];
        int g;
        if (!reset) begin
            m_rem = 0; m_drain = 0; m_last = 1;
            m_pend[0] = 0; m_pend[1] = 0;
            m_ptr[0] = '0; m_ptr[1] = '0;
            rdq.delete(); wrq.delete(); dq.delete();
        end else begin
            af[0] = pix_afull; af[1] = wt_afull;
            if (m_rem > 0) begin
                if (!af[m_src]) begin
                    rdq.push_back('{cyc, m_src, m_ptr[m_src]});
                    wrq.push_back('{cyc + 1, m_src});
                    m_ptr[m_src] = m_ptr[m_src] + 16'd1;
                    m_rem--;
                    if (m_rem == 0) begin
                        dq.push_back(cyc + 2);
                        m_drain = 1;
                    end
                end
            end else if (m_drain) begin
                m_drain = 0;
            end else begin
                g = -1;
                if (m_pend[0] && m_pend[1]) g = (m_last == 0) ? 1 : 0;
                else if (m_pend[0]) g = 0;
                else if (m_pend[1]) g = 1;
                if (g >= 0) begin
                    m_src = g; m_last = g; m_rem = BURST; m_pend[g] = 0;
                end
            end
            if (cfg_load) begin
                m_ptr[0] = pix_base; m_ptr[1] = wt_base;
            end
            if (pix_req) m_pend[0] = 1;
            if (wt_req) m_pend[1] = 1;
        end
    end

    always @(negedge clk) begin
        rd_t r;
        wr_t w;
        int  d;
        #1;
        if (mem_rd_en) begin
            n_cmp++; n_rd++;
            if (rdq.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected cyc=%0d got addr=%h grant_pix=%b required none", cyc, mem_addr, grant_pix);
            end else begin
                r = rdq.pop_front();
                if (r.cyc != cyc || r.addr != mem_addr || grant_pix != (r.src == 0) || !busy) begin
                    n_bad++;
                    $display("FAIL rd cyc=%0d got addr=%h grant_pix=%b busy=%b required cyc=%0d addr=%h grant_pix=%b busy=1",
                             cyc, mem_addr, grant_pix, busy, r.cyc, r.addr, r.src == 0);
                end
            end
        end
        if (pix_fifo_wr_en || wt_fifo_wr_en) begin
            n_cmp++;
            if (wrq.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected cyc=%0d got pix_wr=%b wt_wr=%b required none", cyc, pix_fifo_wr_en, wt_fifo_wr_en);
            end else begin
                w = wrq.pop_front();
                if (w.cyc != cyc || pix_fifo_wr_en != (w.src == 0) || wt_fifo_wr_en != (w.src == 1)) begin
                    n_bad++;
                    $display("FAIL wr cyc=%0d got pix_wr=%b wt_wr=%b required cyc=%0d pix_wr=%b wt_wr=%b",
                             cyc, pix_fifo_wr_en, wt_fifo_wr_en, w.cyc, w.src == 0, w.src == 1);
                end
            end
        end
        if (burst_done) begin
            n_cmp++;
            if (dq.size() == 0) begin
                n_bad++;
                $display("FAIL done_unexpected cyc=%0d got burst_done=1 required 0", cyc);
            end else begin
                d = dq.pop_front();
                if (d != cyc) begin
                    n_bad++;
                    $display("FAIL done cyc got %0d required %0d", cyc, d);
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk); #1;
            pix_req = 1'b0; wt_req = 1'b0; cfg_load = 1'b0;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, int'(mem_rd_en), 0);
        chk({tag, "_addr"}, int'(mem_addr), 0);
        chk({tag, "_pix_wr"}, int'(pix_fifo_wr_en), 0);
        chk({tag, "_wt_wr"}, int'(wt_fifo_wr_en), 0);
        chk({tag, "_grant_pix"}, int'(grant_pix), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(burst_done), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk_outputs_zero("reset");
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic cfg(input logic [15:0] pb, input logic [15:0] wb);
        pix_base = pb; wt_base = wb; cfg_load = 1'b1;
        step(1);
    endtask

    initial begin
        int start;
        bit hit;
        #2;
        chk_outputs_zero("por");
        step(2);
        reset = 1'b1;
        step(1);

        cfg(16'h0100, 16'hFFFC);
        pix_req = 1'b1; step(1);
        step(20);
        wt_req = 1'b1; step(1);
        step(20);

        do_reset();
        cfg(16'h0200, 16'h0300);
        pix_req = 1'b1; wt_req = 1'b1; step(1);
        step(35);
        pix_req = 1'b1; step(1);
        step(20);
        pix_req = 1'b1; wt_req = 1'b1; step(1);
        step(35);

        cfg(16'h0400, 16'h0500);
        pix_req = 1'b1; step(1);
        step(5);
        pix_afull = 1'b1; step(3);
        pix_afull = 1'b0;
        step(20);

        pix_req = 1'b1; step(4);
        wt_req = 1'b1; step(1);
        step(35);

        start = n_rd;
        hit = 0;
        pix_req = 1'b1; step(1);
        for (int i = 0; i < 50 && !hit; i++) begin
            if (n_rd - start >= 5) hit = 1;
            else step(1);
        end
        chk("reads_before_reset_seen", int'(hit), 1);
        reset = 1'b0;
        #1;
        chk_outputs_zero("midburst");
        step(2);
        reset = 1'b1;
        step(15);
        chk("quiet_after_reset_reads", n_rd - start, 5);
        wt_req = 1'b1; step(1);
        step(20);

        for (int i = 0; i < 600; i++) begin
            pix_req   = ($urandom_range(7) == 0);
            wt_req    = ($urandom_range(7) == 0);
            pix_afull = ($urandom_range(3) == 0);
            wt_afull  = ($urandom_range(3) == 0);
            if ($urandom_range(49) == 0) begin
                cfg_load = 1'b1;
                pix_base = 16'($urandom);
                wt_base  = 16'($urandom);
            end
            step(1);
        end
        pix_afull = 1'b0; wt_afull = 1'b0;
        step(60);

        chk("rdq_empty", rdq.size(), 0);
        chk("wrq_empty", wrq.size(), 0);
        chk("doneq_empty", dq.size(), 0);
        chk("idle_at_end", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
